// File: rtl/conway_pkg.sv
`default_nettype none
// ============================================================================
// Package     : conway_pkg
// Description : Shared types and constants for the Game-of-Life evaluators.
// Revision    : 1.0 - initial release
// ============================================================================
package conway_pkg;

  // Evaluator sequencing: waiting for the current cell, summing neighbours,
  // presenting the result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam int MAX_NEIGHBORS = 8;
  localparam int COUNT_W       = 4;

  // Classic Conway rule B3/S23, indexed by live-neighbour count.
  localparam logic [MAX_NEIGHBORS:0] DEFAULT_BIRTH_MASK   = 9'b000001000;
  localparam logic [MAX_NEIGHBORS:0] DEFAULT_SURVIVE_MASK = 9'b000001100;

endpackage : conway_pkg
`default_nettype wire

// File: rtl/conway_serial_cell_evaluator_if.sv
`default_nettype none
// ============================================================================
// Interface   : conway_serial_cell_evaluator_if
// Description : Neighbour-bit input stream and result output stream of the
//               serial cell evaluator. The master side is the upstream scan
//               sequencer plus the downstream writer; the slave side is the
//               evaluator itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface conway_serial_cell_evaluator_if;
  import conway_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic               in_bit;
  logic               out_valid;
  logic               out_ready;
  logic               next_cell;
  logic [COUNT_W-1:0] count;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, next_cell, count
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, next_cell, count
  );

endinterface : conway_serial_cell_evaluator_if
`default_nettype wire

// File: rtl/conway_rule_lookup.sv
`default_nettype none
// ============================================================================
// Module      : conway_rule_lookup
// Description : Combinational birth/survive rule. Selects the mask bit for
//               the neighbour count, using the survive mask for a live cell
//               and the birth mask for a dead one.
// Revision    : 1.0 - initial release
// ============================================================================
module conway_rule_lookup
  import conway_pkg::*;
(
  input  wire logic                     current,
  input  wire logic [COUNT_W-1:0]       count,
  input  wire logic [MAX_NEIGHBORS:0]   birth_mask,
  input  wire logic [MAX_NEIGHBORS:0]   survive_mask,
  output logic                          next_cell
);

  // Counts beyond the mask width cannot occur in a legal neighbourhood;
  // they map to a dead cell rather than an out-of-range select.
  always_comb begin
    next_cell = 1'b0;
    if (count <= COUNT_W'(MAX_NEIGHBORS)) begin
      next_cell = current ? survive_mask[count] : birth_mask[count];
    end
  end

endmodule : conway_rule_lookup
`default_nettype wire

// File: rtl/conway_serial_cell_evaluator.sv
`default_nettype none
// ============================================================================
// Module      : conway_serial_cell_evaluator
// Description : Serial Game-of-Life cell evaluator. Takes the current cell
//               bit followed by NEIGHBORS neighbour bits over a valid/ready
//               stream, counts live neighbours and presents the next-cell
//               state and count on a registered valid/ready output.
//               NEIGHBORS must lie in 1..8.
// Revision    : 1.0 - initial release
// ============================================================================
module conway_serial_cell_evaluator
  import conway_pkg::*;
#(
  parameter int                       NEIGHBORS    = 8,
  parameter logic [MAX_NEIGHBORS:0]   BIRTH_MASK   = DEFAULT_BIRTH_MASK,
  parameter logic [MAX_NEIGHBORS:0]   SURVIVE_MASK = DEFAULT_SURVIVE_MASK
)
(
  input  wire logic                     clk,
  input  wire logic                     rst,
  conway_serial_cell_evaluator_if.slave bus
);

  localparam logic [COUNT_W-1:0] LAST_BEAT = COUNT_W'(NEIGHBORS);

  state_t             state;
  state_t             state_nx;
  logic [COUNT_W-1:0] beat_cnt;
  logic [COUNT_W-1:0] nb_cnt;
  logic [COUNT_W-1:0] nb_cnt_nx;
  logic [COUNT_W-1:0] count_q;
  logic               current;
  logic               next_cell_q;
  logic               rule_out;
  logic               xfer;
  logic               last_beat;

  // Input is refused while a result is pending (back-pressure) and while in
  // reset; the result is withdrawn while reset is applied.
  assign bus.in_ready  = (state != RESULT) && !rst;
  assign bus.out_valid = (state == RESULT) && !rst;
  assign bus.next_cell = next_cell_q;
  assign bus.count     = count_q;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign last_beat = (state == ACCUM) && (beat_cnt == LAST_BEAT);
  assign nb_cnt_nx = nb_cnt + {{(COUNT_W-1){1'b0}}, bus.in_bit};

  // The rule sees the count including the beat being accepted, so the
  // result can be registered on the final neighbour transfer.
  conway_rule_lookup u_rule (
    .current      (current),
    .count        (nb_cnt_nx),
    .birth_mask   (BIRTH_MASK),
    .survive_mask (SURVIVE_MASK),
    .next_cell    (rule_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: one cell per pass IDLE -> ACCUM -> RESULT -> IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (xfer)              state_nx = ACCUM;
      ACCUM:   if (xfer && last_beat) state_nx = RESULT;
      RESULT:  if (bus.out_ready)     state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  // Datapath: capture the cell, accumulate neighbours, latch the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      current     <= 1'b0;
      nb_cnt      <= '0;
      beat_cnt    <= '0;
      next_cell_q <= 1'b0;
      count_q     <= '0;
    end else if (xfer) begin
      if (state == IDLE) begin
        current  <= bus.in_bit;
        nb_cnt   <= '0;
        beat_cnt <= COUNT_W'(1);
      end else begin
        nb_cnt   <= nb_cnt_nx;
        beat_cnt <= beat_cnt + 1'b1;
        if (last_beat) begin
          next_cell_q <= rule_out;
          count_q     <= nb_cnt_nx;
        end
      end
    end
  end

endmodule : conway_serial_cell_evaluator
`default_nettype wire

// File: tb/tb_conway_serial_cell_evaluator.sv
`default_nettype none
// ============================================================================
// Module      : tb_conway_serial_cell_evaluator
// Description : Self-checking bench for the serial cell evaluator. A queue of
//               expected results built from the B3/S23 rule is compared
//               against every presented result; directed cases pin literal
//               values, latency, back-pressure and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conway_serial_cell_evaluator;

  typedef struct {
    logic       nc;
    logic [3:0] cnt;
  } exp_t;

  localparam logic [8:0] BIRTH   = 9'b000001000;
  localparam logic [8:0] SURVIVE = 9'b000001100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  conway_serial_cell_evaluator_if bus ();

  conway_serial_cell_evaluator #(
    .NEIGHBORS    (8),
    .BIRTH_MASK   (BIRTH),
    .SURVIVE_MASK (SURVIVE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Rule applied directly to the neighbour population.
  function automatic exp_t model(input logic cur, input logic [7:0] nb);
    exp_t e;
    int   n;
    n     = $countones(nb);
    e.cnt = 4'(n);
    e.nc  = cur ? SURVIVE[n] : BIRTH[n];
    return e;
  endfunction

  // Per-cycle compare against the model queue.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_vs_valid", bus.in_ready, !bus.out_valid);
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          check("model_next_cell", bus.next_cell, q[0].nc);
          check("model_count", bus.count, q[0].cnt);
          if (bus.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  // One beat: hold it until a transfer edge, bounded.
  task automatic do_beat(input logic b);
    logic took;
    int   guard;
    took  = 1'b0;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    while (!took && guard < 50) begin
      took = bus.in_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!took) check("beat_accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b1;
  endtask

  // Full cell; first listed neighbour is nb[7]. Returns cycles from first
  // beat presentation to the cycle the result should be visible.
  task automatic send_cell(input logic cur, input logic [7:0] nb, input int stall,
                           output int cycles);
    int start;
    q.push_back(model(cur, nb));
    start = cyc;
    do_beat(cur);
    for (int i = 7; i >= 0; i--) begin
      repeat (stall) begin
        @(posedge clk); #1;
      end
      do_beat(nb[i]);
    end
    cycles = cyc - start;
  endtask

  task automatic run_cell(input string tag, input logic cur, input logic [7:0] nb,
                          input int stall, input logic exp_nc, input int exp_cnt,
                          input int exp_cycles);
    int cycles;
    send_cell(cur, nb, stall, cycles);
    check({tag, "_latency"}, cycles, exp_cycles);
    check({tag, "_out_valid"}, bus.out_valid, 1);
    check({tag, "_next_cell"}, bus.next_cell, exp_nc);
    check({tag, "_count"}, bus.count, exp_cnt);
    @(posedge clk); #1;
    check({tag, "_idle_valid"}, bus.out_valid, 0);
    check({tag, "_idle_ready"}, bus.in_ready, 1);
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int cycles;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_next_cell", bus.next_cell, 0);
    check("reset_count", bus.count, 0);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Blinker centre, births, over/under-population.
    run_cell("blinker", 1'b1, 8'b00010100, 0, 1'b1, 2, 9);
    run_cell("birth3",  1'b0, 8'b11100000, 0, 1'b1, 3, 9);
    run_cell("dead4",   1'b0, 8'b11110000, 0, 1'b0, 4, 9);
    run_cell("over8",   1'b1, 8'b11111111, 0, 1'b0, 8, 9);
    run_cell("under0",  1'b1, 8'b00000000, 0, 1'b0, 0, 9);

    // Back-pressure: result held, upstream beats refused.
    bus.out_ready = 1'b0;
    send_cell(1'b1, 8'b10100000, 0, cycles);
    check("bp_latency", cycles, 9);
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_next_cell", bus.next_cell, 1);
      check("bp_count", bus.count, 2);
      check("bp_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", bus.out_valid, 0);
    check("bp_release_ready", bus.in_ready, 1);

    // Stalled input: one idle cycle between beats.
    run_cell("stall", 1'b0, 8'b01010100, 1, 1'b1, 3, 17);

    // Reset mid-cell after four neighbour beats.
    do_beat(1'b1);
    for (int i = 0; i < 4; i++) do_beat(1'b1);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_count", bus.count, 0);
    check("midrst_next_cell", bus.next_cell, 0);
    check("midrst_in_ready_after", bus.in_ready, 1);
    @(posedge clk); #1;
    run_cell("post_rst", 1'b1, 8'b01000100, 0, 1'b1, 2, 9);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_conway_serial_cell_evaluator
`default_nettype wire

// File: doc/conway_serial_cell_evaluator.md
Name: conway_serial_cell_evaluator

Overview:
- Serial consumer of neighbour bits for the Game-of-Life datapath.
- Accepts one current-cell bit, then NEIGHBORS neighbour bits, over a valid/ready stream.
- Accumulates the live-neighbour count and applies the birth/survive rule.
- Presents next-cell state and count on a valid/ready output; sits between the grid-scan sequencer and the next-generation writer.

Parameters:
NEIGHBORS, 8, neighbour beats per cell; legal range 1..8.
BIRTH_MASK, 9'b000001000, bit n set means a dead cell with n live neighbours becomes live.
SURVIVE_MASK, 9'b000001100, bit n set means a live cell with n live neighbours stays live.

Ports:
CLK  input  1  clock, all logic on rising edge
RESET  input  1  synchronous, active-high reset
IN_VALID  input  1  upstream beat valid
IN_READY  output  1  evaluator can accept a beat
IN_BIT  input  1  beat 0 = current cell state; beats 1..NEIGHBORS = neighbour bits
OUT_VALID  output  1  result valid
OUT_READY  input  1  downstream accepts result
NEXT_CELL  output  1  next-generation cell state
COUNT  output  4  live-neighbour count, 0..NEIGHBORS

Behaviour:
- Reset: synchronous, active-high, sampled on CLK rising edge; overrides all other inputs in the same cycle.
  - State=IDLE; IN_READY=0 during the RESET cycle and 1 from the first cycle after RESET deasserts.
  - OUT_VALID=0, NEXT_CELL=0, COUNT=0, internal beat counter=0.
- Beat acceptance: a beat transfers on a rising edge with IN_VALID&&IN_READY.
  - IN_VALID may drop between beats; no transfer occurs then and state is held.
  - IN_BIT is don't-care when no transfer occurs.
- States:
  - IDLE: IN_READY=1, OUT_VALID=0. On transfer, capture IN_BIT as current cell, clear count, beat counter=1, go to ACCUM.
  - ACCUM: IN_READY=1. On transfer, count += IN_BIT and beat counter += 1. On the transfer where beat counter==NEIGHBORS, go to RESULT.
  - RESULT: IN_READY=0, OUT_VALID=1. NEXT_CELL = current ? SURVIVE_MASK[count] : BIRTH_MASK[count]; COUNT = count. Outputs are registered and stable while OUT_VALID&&!OUT_READY. On OUT_READY, go to IDLE.
- Latency: OUT_VALID asserts the cycle after the final neighbour beat transfers. With IN_VALID held high and OUT_READY=1, one cell takes NEIGHBORS+2 cycles (1 current + NEIGHBORS neighbours + 1 result).
- No input/output overlap: IN_READY stays 0 in RESULT, so back-pressure propagates upstream.
- Count width: 4 bits. Saturation is not possible because count ≤ NEIGHBORS ≤ 8. Mask bits above NEIGHBORS are ignored.
- Reset mid-cell (ACCUM or RESULT): partial count discarded, return to IDLE, no result emitted.
- OUT_READY high outside RESULT: ignored.
- NEXT_CELL/COUNT outside RESULT: hold last result, or 0 after reset; consumers must qualify with OUT_VALID.

Decomposition:
- Shared package conway_pkg:
  - state enum {IDLE, ACCUM, RESULT}
  - constant MAX_NEIGHBORS=8
  - constant COUNT_W=4
  - default rule masks B3/S23
- One sub-module, conway_rule_lookup: combinational (current, count, masks) -> next cell. It is reused by the parallel evaluator.
- Count increment uses plain RTL add, not an adder-tree instance.

Test Plan:
- Blinker centre: beats 1, then 0,0,0,1,0,1,0,0 (count 2) -> OUT_VALID at cycle 10 after first beat, NEXT_CELL=1, COUNT=2.
- Birth: current 0, neighbours 1,1,1,0,0,0,0,0 -> NEXT_CELL=1, COUNT=3. Then current 0 with 4 live -> NEXT_CELL=0, COUNT=4.
- Over/under-population: current 1 with 8 live -> NEXT_CELL=0, COUNT=8. Current 1 with 0 live -> NEXT_CELL=0, COUNT=0.
- Back-pressure: hold OUT_READY=0 for 5 cycles in RESULT -> OUT_VALID, NEXT_CELL and COUNT stable, IN_READY=0, upstream beats not consumed. Release -> IDLE next cycle, IN_READY=1.
- Stalled input: IN_VALID toggled 1,0,1,0 across beats -> same result as the contiguous case (count 3 -> NEXT_CELL=1), latency extended by the stall cycles.
- Reset mid-cell: RESET after beat 4 in ACCUM -> next cycle IDLE, OUT_VALID=0, COUNT=0. A following full cell with 2 live and current 1 -> NEXT_CELL=1, COUNT=2, with no stale contribution.
